// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared bus widths, access sizes and controller state codes
package mem_access_ctrl_pkg;

    localparam int DATA_BUS_WIDTH     = 32;
    localparam int ADDR_BUS_WIDTH     = 32;
    localparam int MEM_SEL_BUS_WIDTH  = 4;
    localparam int MEM_SIZE_BUS_WIDTH = 2;

    localparam logic [MEM_SIZE_BUS_WIDTH-1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [MEM_SIZE_BUS_WIDTH-1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [MEM_SIZE_BUS_WIDTH-1:0] MEM_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        MEMCTRL_IDLE  = 2'b00,
        MEMCTRL_WAIT  = 2'b01,
        MEMCTRL_DONE  = 2'b10,
        MEMCTRL_DRAIN = 2'b11
    } memctrl_state_t;

endpackage

// File: rtl/mem_store_align.sv
// rtl/mem_store_align.sv - byte-lane select, store-data replication and alignment check
module mem_store_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [MEM_SIZE_BUS_WIDTH-1:0] size,
    input  logic [1:0]                    addr_lo,
    input  logic [DATA_BUS_WIDTH-1:0]     data_in,
    output logic [MEM_SEL_BUS_WIDTH-1:0]  byte_sel,
    output logic [DATA_BUS_WIDTH-1:0]     data_out,
    output logic                          misaligned
);

    always_comb begin
        byte_sel   = 4'b1111;
        data_out   = data_in;
        misaligned = 1'b0;
        case (size)
            MEM_SIZE_BYTE: begin
                byte_sel = 4'b0001 << addr_lo;
                data_out = {4{data_in[7:0]}};
            end
            MEM_SIZE_HALF: begin
                byte_sel   = 4'b0011 << {addr_lo[1], 1'b0};
                data_out   = {2{data_in[15:0]}};
                misaligned = addr_lo[0];
            end
            // size 11 behaves exactly like a word access
            default: begin
                byte_sel   = 4'b1111;
                data_out   = data_in;
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data-memory access controller with req/ack RAM handshake
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_BUS_WIDTH,
    parameter int DATA_WIDTH = DATA_BUS_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          stall_pipe,
    input  logic                          mem_read_flag_in,
    input  logic                          mem_write_flag_in,
    input  logic [MEM_SIZE_BUS_WIDTH-1:0] mem_size_in,
    input  logic [ADDR_WIDTH-1:0]         addr_in,
    input  logic [DATA_WIDTH-1:0]         write_data_in,
    input  logic                          ram_ack,
    input  logic [DATA_WIDTH-1:0]         ram_read_data_in,
    output logic                          ram_en,
    output logic [MEM_SEL_BUS_WIDTH-1:0]  ram_write_en,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_write_data,
    output logic [DATA_WIDTH-1:0]         ram_read_data_out,
    output logic [MEM_SEL_BUS_WIDTH-1:0]  mem_sel_out,
    output logic                          stall_request,
    output logic                          exc_load_addr,
    output logic                          exc_store_addr,
    output logic [ADDR_WIDTH-1:0]         bad_vaddr
);

    memctrl_state_t                 state;
    logic                           is_load;
    logic [MEM_SEL_BUS_WIDTH-1:0]   byte_sel;
    logic [DATA_WIDTH-1:0]          aligned_data;
    logic                           misaligned;
    logic                           mem_op;
    logic                           access;

    mem_store_align u_align (
        .size       (mem_size_in),
        .addr_lo    (addr_in[1:0]),
        .data_in    (write_data_in),
        .byte_sel   (byte_sel),
        .data_out   (aligned_data),
        .misaligned (misaligned)
    );

    assign mem_op = mem_read_flag_in | mem_write_flag_in;
    assign access = mem_op & ~misaligned & ~flush;

    // Exceptions are gated by reset so every output reads zero while rst is low.
    assign exc_load_addr  = rst & mem_read_flag_in  & misaligned & ~flush;
    assign exc_store_addr = rst & mem_write_flag_in & misaligned & ~flush;
    assign bad_vaddr      = (exc_load_addr | exc_store_addr) ? addr_in : '0;

    // Stall must be combinational in IDLE so the issuing instruction is held from its first cycle.
    always_comb begin
        stall_request = 1'b0;
        if (rst) begin
            case (state)
                MEMCTRL_IDLE:  stall_request = access;
                MEMCTRL_WAIT:  stall_request = 1'b1;
                MEMCTRL_DRAIN: stall_request = mem_op;
                default:       stall_request = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= MEMCTRL_IDLE;
            is_load           <= 1'b0;
            ram_en            <= 1'b0;
            ram_write_en      <= '0;
            ram_addr          <= '0;
            ram_write_data    <= '0;
            ram_read_data_out <= '0;
            mem_sel_out       <= '0;
        end else begin
            case (state)
                MEMCTRL_IDLE: begin
                    if (access) begin
                        ram_en         <= 1'b1;
                        ram_write_en   <= mem_write_flag_in ? byte_sel : '0;
                        ram_addr       <= {addr_in[ADDR_WIDTH-1:2], 2'b00};
                        ram_write_data <= aligned_data;
                        mem_sel_out    <= byte_sel;
                        is_load        <= mem_read_flag_in & ~mem_write_flag_in;
                        state          <= MEMCTRL_WAIT;
                    end
                end
                MEMCTRL_WAIT: begin
                    if (ram_ack) begin
                        ram_en       <= 1'b0;
                        ram_write_en <= '0;
                        if (flush) begin
                            state <= MEMCTRL_IDLE;
                        end else begin
                            ram_read_data_out <= is_load ? ram_read_data_in : '0;
                            state             <= MEMCTRL_DONE;
                        end
                    end else if (flush) begin
                        state <= MEMCTRL_DRAIN;
                    end
                end
                MEMCTRL_DONE: begin
                    if (!stall_pipe || flush) begin
                        state <= MEMCTRL_IDLE;
                    end
                end
                MEMCTRL_DRAIN: begin
                    // The bus request stays up until the RAM completes it; its data is dropped.
                    if (ram_ack) begin
                        ram_en       <= 1'b0;
                        ram_write_en <= '0;
                        state        <= MEMCTRL_IDLE;
                    end
                end
                default: state <= MEMCTRL_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        stall_pipe;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ram_ack;
    logic [31:0] ram_rdata;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic [31:0] rdata_out;
    logic [3:0]  sel_out;
    logic        stall_request;
    logic        exc_load;
    logic        exc_store;
    logic [31:0] bad_vaddr;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cycles;
    int stall_cycles;

    mem_access_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .stall_pipe        (stall_pipe),
        .mem_read_flag_in  (rd),
        .mem_write_flag_in (wr),
        .mem_size_in       (size),
        .addr_in           (addr),
        .write_data_in     (wdata),
        .ram_ack           (ram_ack),
        .ram_read_data_in  (ram_rdata),
        .ram_en            (ram_en),
        .ram_write_en      (ram_write_en),
        .ram_addr          (ram_addr),
        .ram_write_data    (ram_write_data),
        .ram_read_data_out (rdata_out),
        .mem_sel_out       (sel_out),
        .stall_request     (stall_request),
        .exc_load_addr     (exc_load),
        .exc_store_addr    (exc_store),
        .bad_vaddr         (bad_vaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_en) en_cycles++;
        if (stall_request) stall_cycles++;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL reset_ram_en got %b want 0", ram_en); end
        n_checks++; if (ram_write_en !== 4'h0) begin n_fail++; $display("FAIL reset_write_en got %h want 0", ram_write_en); end
        n_checks++; if (ram_addr !== 32'h0) begin n_fail++; $display("FAIL reset_ram_addr got %h want 0", ram_addr); end
        n_checks++; if (rdata_out !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata_out); end
        n_checks++; if (sel_out !== 4'h0) begin n_fail++; $display("FAIL reset_sel got %h want 0", sel_out); end
        n_checks++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall_request); end
        step;
        step;
        rst = 1'b1;
    endtask

    task automatic test_word_load;
        step; en_cycles = 0; stall_cycles = 0;
        rd = 1'b1; size = 2'b10; addr = 32'h100;
        @(negedge clk);
        n_checks++; if (stall_request !== 1'b1) begin n_fail++; $display("FAIL wl_c0_stall got %b want 1", stall_request); end
        n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL wl_c0_ram_en got %b want 0", ram_en); end
        step; ram_ack = 1'b1; ram_rdata = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++; if (ram_en !== 1'b1) begin n_fail++; $display("FAIL wl_c1_ram_en got %b want 1", ram_en); end
        n_checks++; if (ram_addr !== 32'h100) begin n_fail++; $display("FAIL wl_c1_ram_addr got %h want 100", ram_addr); end
        n_checks++; if (ram_write_en !== 4'h0) begin n_fail++; $display("FAIL wl_c1_write_en got %h want 0", ram_write_en); end
        step; ram_ack = 1'b0; ram_rdata = 32'h0;
        @(negedge clk);
        n_checks++; if (rdata_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wl_c2_rdata got %h want deadbeef", rdata_out); end
        n_checks++; if (sel_out !== 4'b1111) begin n_fail++; $display("FAIL wl_c2_sel got %b want 1111", sel_out); end
        n_checks++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL wl_c2_stall got %b want 0", stall_request); end
        n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL wl_c2_ram_en got %b want 0", ram_en); end
        step; rd = 1'b0;
        @(negedge clk);
        n_checks++; if (en_cycles !== 1) begin n_fail++; $display("FAIL wl_en_cycles got %0d want 1", en_cycles); end
        n_checks++; if (stall_cycles !== 2) begin n_fail++; $display("FAIL wl_stall_cycles got %0d want 2", stall_cycles); end
    endtask

    task automatic test_byte_store;
        step; en_cycles = 0; stall_cycles = 0;
        wr = 1'b1; size = 2'b00; addr = 32'h203; wdata = 32'h0000_00A5;
        step;
        @(negedge clk);
        n_checks++; if (ram_write_en !== 4'b1000) begin n_fail++; $display("FAIL bs_write_en got %b want 1000", ram_write_en); end
        n_checks++; if (ram_write_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL bs_write_data got %h want a5a5a5a5", ram_write_data); end
        n_checks++; if (ram_addr !== 32'h200) begin n_fail++; $display("FAIL bs_ram_addr got %h want 200", ram_addr); end
        step;
        step; ram_ack = 1'b1;
        step; ram_ack = 1'b0;
        @(negedge clk);
        n_checks++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL bs_done_stall got %b want 0", stall_request); end
        n_checks++; if (rdata_out !== 32'h0) begin n_fail++; $display("FAIL bs_done_rdata got %h want 0", rdata_out); end
        n_checks++; if (ram_write_en !== 4'h0) begin n_fail++; $display("FAIL bs_done_write_en got %b want 0", ram_write_en); end
        step; wr = 1'b0;
        @(negedge clk);
        n_checks++; if (stall_cycles !== 4) begin n_fail++; $display("FAIL bs_stall_cycles got %0d want 4", stall_cycles); end
        n_checks++; if (en_cycles !== 3) begin n_fail++; $display("FAIL bs_en_cycles got %0d want 3", en_cycles); end
    endtask

    task automatic test_misaligned;
        step; en_cycles = 0; stall_cycles = 0;
        rd = 1'b1; size = 2'b01; addr = 32'h101;
        @(negedge clk);
        n_checks++; if (exc_load !== 1'b1) begin n_fail++; $display("FAIL ma_exc_load got %b want 1", exc_load); end
        n_checks++; if (exc_store !== 1'b0) begin n_fail++; $display("FAIL ma_exc_store got %b want 0", exc_store); end
        n_checks++; if (bad_vaddr !== 32'h101) begin n_fail++; $display("FAIL ma_bad_vaddr got %h want 101", bad_vaddr); end
        n_checks++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL ma_stall got %b want 0", stall_request); end
        step;
        step;
        @(negedge clk);
        n_checks++; if (en_cycles !== 0) begin n_fail++; $display("FAIL ma_en_cycles got %0d want 0", en_cycles); end
        n_checks++; if (stall_cycles !== 0) begin n_fail++; $display("FAIL ma_stall_cycles got %0d want 0", stall_cycles); end
        rd = 1'b0; wr = 1'b1; size = 2'b10; addr = 32'h102;
        #1;
        n_checks++; if (exc_store !== 1'b1) begin n_fail++; $display("FAIL ma_word_exc_store got %b want 1", exc_store); end
        n_checks++; if (bad_vaddr !== 32'h102) begin n_fail++; $display("FAIL ma_word_bad_vaddr got %h want 102", bad_vaddr); end
        size = 2'b11; addr = 32'h201;
        #1;
        n_checks++; if (exc_store !== 1'b1) begin n_fail++; $display("FAIL ma_size3_exc_store got %b want 1", exc_store); end
        size = 2'b01; addr = 32'h102;
        #1;
        n_checks++; if (exc_store !== 1'b0) begin n_fail++; $display("FAIL ma_half_ok_exc got %b want 0", exc_store); end
        n_checks++; if (bad_vaddr !== 32'h0) begin n_fail++; $display("FAIL ma_half_ok_bad_vaddr got %h want 0", bad_vaddr); end
        wr = 1'b0;
    endtask

    task automatic test_stall_done;
        step; en_cycles = 0;
        rd = 1'b1; size = 2'b01; addr = 32'h106;
        step; ram_ack = 1'b1; ram_rdata = 32'h12345678;
        @(negedge clk);
        n_checks++; if (ram_addr !== 32'h104) begin n_fail++; $display("FAIL sd_ram_addr got %h want 104", ram_addr); end
        step; ram_ack = 1'b0; stall_pipe = 1'b1;
        @(negedge clk);
        n_checks++; if (rdata_out !== 32'h12345678) begin n_fail++; $display("FAIL sd_c2_rdata got %h want 12345678", rdata_out); end
        n_checks++; if (sel_out !== 4'b1100) begin n_fail++; $display("FAIL sd_c2_sel got %b want 1100", sel_out); end
        n_checks++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL sd_c2_stall got %b want 0", stall_request); end
        step; ram_ack = 1'b1; ram_rdata = 32'h87654321;
        @(negedge clk);
        n_checks++; if (rdata_out !== 32'h12345678) begin n_fail++; $display("FAIL sd_c3_rdata got %h want 12345678", rdata_out); end
        n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL sd_c3_ram_en got %b want 0", ram_en); end
        step; ram_ack = 1'b0; stall_pipe = 1'b0;
        @(negedge clk);
        n_checks++; if (rdata_out !== 32'h12345678) begin n_fail++; $display("FAIL sd_c4_rdata got %h want 12345678", rdata_out); end
        n_checks++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL sd_c4_stall got %b want 0", stall_request); end
        step; rd = 1'b0;
        @(negedge clk);
        n_checks++; if (en_cycles !== 1) begin n_fail++; $display("FAIL sd_en_cycles got %0d want 1", en_cycles); end
    endtask

    task automatic test_flush_drain;
        step;
        rd = 1'b1; size = 2'b10; addr = 32'h300;
        step;
        step; flush = 1'b1;
        @(negedge clk);
        n_checks++; if (ram_en !== 1'b1) begin n_fail++; $display("FAIL fd_c2_ram_en got %b want 1", ram_en); end
        step; flush = 1'b0; addr = 32'h400;
        @(negedge clk);
        n_checks++; if (ram_en !== 1'b1) begin n_fail++; $display("FAIL fd_drain_ram_en got %b want 1", ram_en); end
        n_checks++; if (ram_addr !== 32'h300) begin n_fail++; $display("FAIL fd_drain_addr got %h want 300", ram_addr); end
        n_checks++; if (stall_request !== 1'b1) begin n_fail++; $display("FAIL fd_drain_stall got %b want 1", stall_request); end
        step; ram_ack = 1'b1; ram_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        n_checks++; if (ram_en !== 1'b1) begin n_fail++; $display("FAIL fd_ack_ram_en got %b want 1", ram_en); end
        step; ram_ack = 1'b0;
        @(negedge clk);
        n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL fd_idle_ram_en got %b want 0", ram_en); end
        n_checks++; if (stall_request !== 1'b1) begin n_fail++; $display("FAIL fd_idle_stall got %b want 1", stall_request); end
        n_checks++; if (rdata_out !== 32'h12345678) begin n_fail++; $display("FAIL fd_discard_rdata got %h want 12345678", rdata_out); end
        step; ram_ack = 1'b1; ram_rdata = 32'hCAFEF00D;
        @(negedge clk);
        n_checks++; if (ram_en !== 1'b1) begin n_fail++; $display("FAIL fd_new_ram_en got %b want 1", ram_en); end
        n_checks++; if (ram_addr !== 32'h400) begin n_fail++; $display("FAIL fd_new_addr got %h want 400", ram_addr); end
        step; ram_ack = 1'b0;
        @(negedge clk);
        n_checks++; if (rdata_out !== 32'hCAFEF00D) begin n_fail++; $display("FAIL fd_new_rdata got %h want cafef00d", rdata_out); end
        n_checks++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL fd_new_stall got %b want 0", stall_request); end
        step; rd = 1'b0;
    endtask

    task automatic test_flush_ack;
        step; en_cycles = 0;
        rd = 1'b1; size = 2'b10; addr = 32'h500;
        step; ram_ack = 1'b1; flush = 1'b1; ram_rdata = 32'h11111111;
        step; ram_ack = 1'b0; flush = 1'b0; rd = 1'b0;
        @(negedge clk);
        n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL fa_ram_en got %b want 0", ram_en); end
        n_checks++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL fa_stall got %b want 0", stall_request); end
        n_checks++; if (rdata_out !== 32'hCAFEF00D) begin n_fail++; $display("FAIL fa_rdata got %h want cafef00d", rdata_out); end
        step;
        @(negedge clk);
        n_checks++; if (en_cycles !== 1) begin n_fail++; $display("FAIL fa_en_cycles got %0d want 1", en_cycles); end
    endtask

    task automatic test_async_reset;
        step;
        wr = 1'b1; size = 2'b10; addr = 32'h600; wdata = 32'h13579BDF;
        step;
        @(negedge clk);
        n_checks++; if (ram_write_en !== 4'b1111) begin n_fail++; $display("FAIL ar_write_en got %b want 1111", ram_write_en); end
        n_checks++; if (ram_write_data !== 32'h13579BDF) begin n_fail++; $display("FAIL ar_write_data got %h want 13579bdf", ram_write_data); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL ar_ram_en got %b want 0", ram_en); end
        n_checks++; if (ram_write_en !== 4'h0) begin n_fail++; $display("FAIL ar_write_en0 got %b want 0", ram_write_en); end
        n_checks++; if (ram_addr !== 32'h0) begin n_fail++; $display("FAIL ar_ram_addr got %h want 0", ram_addr); end
        n_checks++; if (ram_write_data !== 32'h0) begin n_fail++; $display("FAIL ar_write_data0 got %h want 0", ram_write_data); end
        n_checks++; if (rdata_out !== 32'h0) begin n_fail++; $display("FAIL ar_rdata got %h want 0", rdata_out); end
        n_checks++; if (sel_out !== 4'h0) begin n_fail++; $display("FAIL ar_sel got %b want 0", sel_out); end
        n_checks++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL ar_stall got %b want 0", stall_request); end
        step; rst = 1'b1; wr = 1'b0;
        @(negedge clk);
        n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL ar_post_ram_en got %b want 0", ram_en); end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; stall_pipe = 1'b0; rd = 1'b0; wr = 1'b0;
        size = 2'b10; addr = 32'h0; wdata = 32'h0; ram_ack = 1'b0; ram_rdata = 32'h0;
        en_cycles = 0; stall_cycles = 0;
        test_reset;
        test_word_load;
        test_byte_store;
        test_misaligned;
        test_stall_done;
        test_flush_drain;
        test_flush_ack;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Data-memory access controller for the MEM stage. It sits between the EX/MEM pipeline register and the MEM/WB register.
- Turns a load/store request from EX/MEM into a byte-lane-aligned RAM bus transaction with a request/acknowledge handshake.
- Raises a stall request while the transaction is outstanding.
- Holds the returned read data stable until MEM/WB samples it.
- Detects misaligned addresses and blocks the access, reporting an address-error exception instead.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, data width; fixed at 4 byte lanes.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  discard current MEM-stage instruction.
- stall_pipe  in  1  MEM/WB not advancing this cycle (global stall from pipeline controller).
- mem_read_flag_in  in  1  load in MEM stage.
- mem_write_flag_in  in  1  store in MEM stage.
- mem_size_in  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- addr_in  in  ADDR_WIDTH  effective byte address.
- write_data_in  in  DATA_WIDTH  store data, right-justified.
- ram_ack  in  1  RAM accepted/completed the current request.
- ram_read_data_in  in  DATA_WIDTH  RAM read data; valid only in the ram_ack cycle.
- ram_en  out  1  request valid, registered.
- ram_write_en  out  4  byte write enables, registered; zero for loads.
- ram_addr  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00}), registered.
- ram_write_data  out  DATA_WIDTH  lane-replicated store data, registered.
- ram_read_data_out  out  DATA_WIDTH  captured read data to MEM/WB.
- mem_sel_out  out  4  byte-lane select to MEM/WB (for load extraction).
- stall_request  out  1  asks the pipeline controller to hold IF..MEM.
- exc_load_addr  out  1  misaligned load (AdEL).
- exc_store_addr  out  1  misaligned store (AdES).
- bad_vaddr  out  ADDR_WIDTH  faulting address; equals addr_in when an exception flag is high, else 0.

## Operation
- access = (mem_read_flag_in | mem_write_flag_in) & ~misaligned & ~flush.
- Misaligned conditions:
  - half with addr[0]=1;
  - word with addr[1:0]≠00.
- Exception outputs are combinational. No RAM request is issued and stall_request stays 0 for a misaligned access.
- Byte select:
  - byte → 0001<<addr[1:0];
  - half → 0011<<{addr[1],1'b0};
  - word → 1111.
- Store data:
  - byte → {4{wd[7:0]}};
  - half → {2{wd[15:0]}};
  - word → wd.
- FSM states: IDLE, WAIT, DONE, DRAIN.
- IDLE:
  - If access, register the request outputs and go to WAIT; stall_request=1.
  - Otherwise stay in IDLE with stall_request=0.
- WAIT:
  - ram_en=1 and outputs are held constant; stall_request=1.
  - On ram_ack, capture ram_read_data_in (loads; stores capture 0), drop ram_en and ram_write_en, go to DONE.
  - On flush without ram_ack, go to DRAIN.
  - On flush with ram_ack, go to IDLE and discard the data.
- DONE:
  - stall_request=0; ram_read_data_out and mem_sel_out are held.
  - If ~stall_pipe or flush, go to IDLE. Otherwise stay; the same instruction must not be re-issued.
- DRAIN:
  - ram_en is kept high, because an issued bus request cannot be withdrawn.
  - stall_request = (mem_read_flag_in|mem_write_flag_in).
  - On ram_ack, discard the data and go to IDLE.
- flush in IDLE has no effect beyond suppressing access.

## Timing
- Reset values: state IDLE; ram_en 0; ram_write_en 0; ram_addr 0; ram_write_data 0; ram_read_data_out 0; mem_sel_out 0; stall_request 0.
- Zero-wait RAM (ram_ack in the first WAIT cycle): IDLE→WAIT→DONE. Read data is valid at ram_read_data_out from the start of cycle 2, and MEM/WB samples it at the end of cycle 2. Total occupancy is 3 cycles.
- Each RAM wait cycle adds exactly one cycle.
- ram_ack is ignored in IDLE and DONE.
- rst asserted mid-transaction returns to IDLE immediately. The RAM side must tolerate the abandoned request.

## Structure
- bus.v gains:
  - MEM_SIZE_BUS and MEM_SIZE_BUS_WIDTH (2);
  - MEM_SIZE_BYTE, MEM_SIZE_HALF, MEM_SIZE_WORD;
  - MEMCTRL_STATE_BUS and the four state codes.
- Reuses DATA_BUS, ADDR_BUS and MEM_SEL_BUS.
- One combinational sub-module, mem_store_align: size+addr+data → byte_sel, replicated data, misaligned flag.

## Test plan
- Word load at 0x100, ram_ack in the first WAIT cycle, ram data 0xDEADBEEF → ram_en high for 1 cycle with ram_addr=0x100. In cycle 2, ram_read_data_out=0xDEADBEEF, mem_sel_out=1111, stall_request=0.
- Byte store 0xA5 to 0x203, ack after 3 wait cycles → ram_write_en=1000, ram_write_data=0xA5A5A5A5, ram_addr=0x200, stall_request high for 4 cycles.
- Half load at 0x101 → exc_load_addr=1, bad_vaddr=0x101, ram_en never asserts, stall_request=0.
- Load acked while stall_pipe=1 for 2 cycles → FSM stays in DONE, data held, no second ram_en.
- flush in the second WAIT cycle, ack 2 cycles later, next instruction a load → DRAIN keeps ram_en high. The first data is discarded and the new load issues only after the ack.
- rst low during WAIT → all outputs 0 asynchronously, before the next clock edge.
